// File: rtl/fetch_decode_if.sv
// Front-end bus between the fetch/decode stage and its environment (hazard unit, imem, decode).
interface fetch_decode_if #(parameter int XLEN = 32);
  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            pc_src_E;
  logic [XLEN-1:0] pc_target_E;
  logic [31:0]     instr_F;
  logic [XLEN-1:0] pc_F;
  logic [31:0]     instr_D;
  logic [XLEN-1:0] pc_D;
  logic [XLEN-1:0] pc_plus4_D;
  logic            valid_D;
  logic            stall_timeout;

  modport master (
    output stallF, stallD, flushD, pc_src_E, pc_target_E, instr_F,
    input  pc_F, instr_D, pc_D, pc_plus4_D, valid_D, stall_timeout
  );

  modport slave (
    input  stallF, stallD, flushD, pc_src_E, pc_target_E, instr_F,
    output pc_F, instr_D, pc_D, pc_plus4_D, valid_D, stall_timeout
  );
endinterface

// File: rtl/fetch_decode_stage.sv
// RV32I front end: PC register, IF/ID register, stall/flush/redirect handling and stall watchdog.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module fetch_decode_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013,
  parameter int unsigned     STALL_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  fetch_decode_if.slave     bus
);

  localparam int CW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   stall_cnt, stall_cnt_n;
  logic            boot, both_stall, stall_f, stall_d;
  logic [XLEN-1:0] pc_plus4_f;

  assign boot       = (state == BOOT);
  assign both_stall = bus.stallF & bus.stallD;
  // The first cycle after reset always advances, whatever the hazard unit says.
  assign stall_f    = bus.stallF & ~boot;
  assign stall_d    = bus.stallD & ~boot;
  assign pc_plus4_f = bus.pc_F + XLEN'(4);

  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = RUN;
      RUN:     if (both_stall) state_n = HOLD;
      HOLD:    if (!both_stall || bus.pc_src_E || bus.flushD) state_n = RUN;
      default: state_n = BOOT;
    endcase
  end

  // Counter value equals the number of consecutive cycles spent in HOLD, saturating.
  always_comb begin
    stall_cnt_n = '0;
    if (state_n == HOLD)
      stall_cnt_n = (stall_cnt == CW'(STALL_MAX)) ? stall_cnt : stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= BOOT;
      stall_cnt         <= '0;
      bus.stall_timeout <= 1'b0;
    end else begin
      state     <= state_n;
      stall_cnt <= stall_cnt_n;
      if (stall_cnt_n == CW'(STALL_MAX)) bus.stall_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                bus.pc_F <= RESET_PC;
    else if (bus.pc_src_E)    bus.pc_F <= bus.pc_target_E;
    else if (!stall_f)        bus.pc_F <= pc_plus4_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_D    <= NOP_INSTR;
      bus.pc_D       <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
    end else if (bus.flushD) begin
      bus.instr_D    <= NOP_INSTR;
      bus.valid_D    <= 1'b0;
    end else if (!stall_d) begin
      bus.instr_D    <= bus.instr_F;
      bus.pc_D       <= bus.pc_F;
      bus.pc_plus4_D <= pc_plus4_f;
      bus.valid_D    <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {31'd0, bus.stallF};
      perf_flush_cnt <= perf_flush_cnt + {31'd0, bus.flushD};
    end
  end
`endif

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Consumer of the hazard unit's stall/flush requests on the front end of the 5-stage RV32I pipeline.
- Holds the program counter and the IF/ID pipeline register, and applies stall, bubble and redirect decisions cycle by cycle.
- Feeds pc_F to the combinational instruction memory and presents instr_D, pc_D and pc_plus4_D to decode.
- Runs a stall watchdog that flags a stuck pipeline.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0)
STALL_MAX, 15, consecutive stall cycles before stall_timeout asserts; must be ≥ 1

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
stallF  input  1  hold PC (from hazard unit)
stallD  input  1  hold IF/ID register (from hazard unit)
flushD  input  1  bubble IF/ID (branch/jump taken in E)
pc_src_E  input  1  redirect PC to pc_target_E
pc_target_E  input  XLEN  branch/jump target from execute
instr_F  input  32  instruction read combinationally at pc_F
pc_F  output  XLEN  current fetch PC
instr_D  output  32  IF/ID instruction
pc_D  output  XLEN  IF/ID PC
pc_plus4_D  output  XLEN  IF/ID PC+4
valid_D  output  1  IF/ID holds a real (non-bubble) instruction
stall_timeout  output  1  sticky watchdog flag

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset, at the clock edge with reset=1:
  - pc_F=RESET_PC; instr_D=NOP_INSTR; pc_D=0; pc_plus4_D=0; valid_D=0; stall_timeout=0.
  - Stall counter=0; FSM→BOOT.
  - Reset mid-stall or mid-redirect discards all in-flight state.
- pc_plus4_F = pc_F + 4, modulo 2^XLEN; wraps from 0xFFFF_FFFC to 0.
- PC update, priority high→low:
  1. reset
  2. pc_src_E → pc_target_E (a redirect overrides stallF)
  3. stallF → hold
  4. otherwise pc_plus4_F
- IF/ID update, priority high→low:
  1. reset
  2. flushD → instr_D=NOP_INSTR, valid_D=0, pc_D/pc_plus4_D unchanged (flush overrides stallD)
  3. stallD → hold all fields
  4. otherwise capture instr_F, pc_F, pc_plus4_F; valid_D=1
- Latency: an instruction fetched at pc_F in cycle N appears on instr_D in cycle N+1.
- FSM states:
  - BOOT: the first cycle after reset. PC advances normally, IF/ID captures with valid_D=1. Stall inputs are ignored here. Next state is RUN.
  - RUN: normal operation per the priority lists above.
  - HOLD: entered from RUN when stallF&stallD. Exited to RUN when the stall drops, or when pc_src_E/flushD asserts.
- Mismatched stalls (stallF=1, stallD=0): the PC holds and IF/ID captures the same instruction again. This is legal but never produced by the hazard unit, and the FSM stays in RUN.
- Watchdog:
  - Counter increments each cycle in HOLD and clears on leaving HOLD.
  - The counter saturates at STALL_MAX.
  - stall_timeout sets when the counter reaches STALL_MAX and stays set until reset.
- All outputs are registered; there is no combinational path from any input to any output except through pc_F→instr_F externally.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt counts cycles with stallF=1.
  - perf_flush_cnt counts cycles with flushD=1.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, instr_F=pc-indexed ROM, no hazards → pc_F 0,4,8,12 on consecutive cycles; instr_D lags by one cycle; valid_D=0 in the reset cycle, then 1.
- Load-use: stallF=stallD=1 for 1 cycle at pc_F=0x10 → pc_F stays 0x10 for 2 cycles; instr_D/pc_D=0x0C held; the sequence then resumes at 0x14.
- Branch: pc_src_E=1, pc_target_E=0x100, flushD=1 at pc_F=0x20 → next pc_F=0x100; instr_D=0x0000_0013, valid_D=0; the next cycle captures the instruction at 0x100.
- Simultaneous: stallF=stallD=1 together with pc_src_E=1, flushD=1, target 0x40 → pc_F=0x40 and a NOP bubble; the redirect and flush win over the stall.
- Watchdog, STALL_MAX=15: hold stalls for 14 cycles → stall_timeout=0; hold for 15 → stall_timeout=1 and stays 1 after the stall drops; reset clears it.
- Wrap/reset: set pc_target_E=0xFFFF_FFFC via a redirect → next pc_F=0; asserting reset during HOLD → pc_F=RESET_PC and valid_D=0 on the next edge.
